// File: rtl/melody_player.sv
// Autoplay sequencer in front of the piano tone generator: forwards switches when idle,
// or plays a fixed 15-note Ode to Joy phrase with programmable note hold and gap times.
module melody_player #(
  parameter int unsigned NOTE_TICKS = 25_000_000,
  parameter int unsigned GAP_TICKS  = 5_000_000,
  parameter int unsigned CNT_W      = 25
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] sw_in,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [7:0] key_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_idx
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned KEY_W = 8;
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(14);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Song ROM: key bit number per entry (7 = C4 ... 0 = C5).
  function automatic logic [2:0] rom_key(input logic [IDX_W-1:0] i);
    case (i)
      4'd0, 4'd1, 4'd6, 4'd11, 4'd12: rom_key = 3'd5;
      4'd2, 4'd5:                     rom_key = 3'd4;
      4'd3, 4'd4:                     rom_key = 3'd3;
      4'd7, 4'd10, 4'd13, 4'd14:      rom_key = 3'd6;
      4'd8, 4'd9:                     rom_key = 3'd7;
      default:                        rom_key = 3'd0;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_NOTE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_NOTE: begin
        if (cnt_q == NOTE_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q < IDX_LAST) begin
            state_d = S_NOTE;
            idx_d   = idx_q + IDX_W'(1);
          end else if (loop) begin
            state_d = S_NOTE;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides start and a coincident natural completion.
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    // Outputs follow the next state so they change on the same edge as the FSM.
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:  key_d = sw_in;
      S_NOTE:  key_d = KEY_W'(1) << rom_key(idx_d);
      default: key_d = '0;
    endcase
  end

  assign key_out  = key_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule
